// File: rtl/ntt_bf_sequencer.sv
// Butterfly address sequencer: buffers generator triples, issues RAM/ROM reads with
// read-after-write hazard stalls, and times the write-back. Define NTT_SEQ_PERF_EN to build stall_cycles.
module ntt_bf_sequencer #(
    parameter int WIDTH_ADDR_BUTTERFLY = 8,
    parameter int WIDTH_ADDR_ZETAS     = 7,
    parameter int FIFO_DEPTH           = 8,
    parameter int RD_LAT               = 1,
    parameter int BF_LAT               = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [WIDTH_ADDR_BUTTERFLY-1:0] gen_addr0,
    input  logic [WIDTH_ADDR_BUTTERFLY-1:0] gen_addr1,
    input  logic [WIDTH_ADDR_ZETAS-1:0]     gen_addr_tw,
    input  logic                            gen_valid,
    input  logic                            gen_finished,
    output logic                            rd_en,
    output logic [WIDTH_ADDR_BUTTERFLY-1:0] rd_addr0,
    output logic [WIDTH_ADDR_BUTTERFLY-1:0] rd_addr1,
    output logic [WIDTH_ADDR_ZETAS-1:0]     rd_addr_tw,
    output logic                            bf_in_valid,
    output logic                            wr_en,
    output logic [WIDTH_ADDR_BUTTERFLY-1:0] wr_addr0,
    output logic [WIDTH_ADDR_BUTTERFLY-1:0] wr_addr1,
    output logic                            busy,
    output logic                            done,
    output logic                            overflow,
    output logic [15:0]                     stall_cycles
);

    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int PIPE_LEN = RD_LAT + BF_LAT;
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0] PTR_INC   = (PTR_W + 1)'(1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t state_q, state_d;
    logic   fin_seen_q, fin_seen_d;
    logic   overflow_q, overflow_d;
    logic   clear_run;

    logic [WIDTH_ADDR_BUTTERFLY-1:0] fifo_a0_q [FIFO_DEPTH];
    logic [WIDTH_ADDR_BUTTERFLY-1:0] fifo_a1_q [FIFO_DEPTH];
    logic [WIDTH_ADDR_ZETAS-1:0]     fifo_tw_q [FIFO_DEPTH];
    logic [PTR_W:0]                  wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]                  fifo_count;
    logic                            fifo_empty, fifo_full;
    logic [WIDTH_ADDR_BUTTERFLY-1:0] head_a0, head_a1;
    logic [WIDTH_ADDR_ZETAS-1:0]     head_tw;

    logic                            pv_q  [1:PIPE_LEN];
    logic [WIDTH_ADDR_BUTTERFLY-1:0] pa0_q [1:PIPE_LEN];
    logic [WIDTH_ADDR_BUTTERFLY-1:0] pa1_q [1:PIPE_LEN];

    logic active, hazard, issue, push_req, push, drop, pipe_busy;

    assign fifo_count = wr_ptr_q - rd_ptr_q;
    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == DEPTH_CNT);
    assign head_a0    = fifo_a0_q[rd_ptr_q[PTR_W-1:0]];
    assign head_a1    = fifo_a1_q[rd_ptr_q[PTR_W-1:0]];
    assign head_tw    = fifo_tw_q[rd_ptr_q[PTR_W-1:0]];

    assign active   = (state_q == RUN) || (state_q == DRAIN);
    assign issue    = active && !fifo_empty && !hazard;
    assign push_req = active && gen_valid;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push     = push_req && (!fifo_full || issue);
    assign drop     = push_req && fifo_full && !issue;

    // The head must not read any address still travelling toward write-back,
    // including the stage whose write lands at the end of this cycle.
    always_comb begin
        hazard    = 1'b0;
        pipe_busy = 1'b0;
        for (int k = 1; k <= PIPE_LEN; k++) begin
            pipe_busy = pipe_busy | pv_q[k];
            if (pv_q[k] && ((head_a0 == pa0_q[k]) || (head_a0 == pa1_q[k]) ||
                            (head_a1 == pa0_q[k]) || (head_a1 == pa1_q[k]))) begin
                hazard = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        fin_seen_d = fin_seen_q;
        overflow_d = overflow_q | drop;
        clear_run  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = RUN;
                    fin_seen_d = 1'b0;
                    overflow_d = 1'b0;
                    clear_run  = 1'b1;
                end
            end
            RUN: begin
                if (gen_finished) fin_seen_d = 1'b1;
                if (fin_seen_q && fifo_empty) state_d = DRAIN;
            end
            DRAIN: begin
                if (!pipe_busy && fifo_empty) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            fin_seen_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fin_seen_q <= fin_seen_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_a0_q[i] <= '0;
                fifo_a1_q[i] <= '0;
                fifo_tw_q[i] <= '0;
            end
        end else if (clear_run) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) begin
                fifo_a0_q[wr_ptr_q[PTR_W-1:0]] <= gen_addr0;
                fifo_a1_q[wr_ptr_q[PTR_W-1:0]] <= gen_addr1;
                fifo_tw_q[wr_ptr_q[PTR_W-1:0]] <= gen_addr_tw;
                wr_ptr_q <= wr_ptr_q + PTR_INC;
            end
            if (issue) rd_ptr_q <= rd_ptr_q + PTR_INC;
        end
    end

    // Stage 1 captures the pair issued this cycle; nothing downstream can stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 1; k <= PIPE_LEN; k++) begin
                pv_q[k]  <= 1'b0;
                pa0_q[k] <= '0;
                pa1_q[k] <= '0;
            end
        end else begin
            pv_q[1]  <= issue;
            pa0_q[1] <= issue ? head_a0 : '0;
            pa1_q[1] <= issue ? head_a1 : '0;
            for (int k = 2; k <= PIPE_LEN; k++) begin
                pv_q[k]  <= pv_q[k-1];
                pa0_q[k] <= pa0_q[k-1];
                pa1_q[k] <= pa1_q[k-1];
            end
        end
    end

`ifdef NTT_SEQ_PERF_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (clear_run) begin
            stall_d = 16'd0;
        end else if (active && !fifo_empty && hazard && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_q <= 16'd0;
        else     stall_q <= stall_d;
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = 16'd0;
`endif

    assign rd_en       = issue;
    assign rd_addr0    = head_a0;
    assign rd_addr1    = head_a1;
    assign rd_addr_tw  = head_tw;
    assign bf_in_valid = pv_q[RD_LAT];
    assign wr_en       = pv_q[PIPE_LEN];
    assign wr_addr0    = pa0_q[PIPE_LEN];
    assign wr_addr1    = pa1_q[PIPE_LEN];
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_ntt_bf_sequencer.sv
// Directed self-checking bench for ntt_bf_sequencer (default parameters).
// Stall expectations follow NTT_SEQ_PERF_EN when the bench is built with it.
module tb_ntt_bf_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] gen_addr0, gen_addr1;
    logic [6:0] gen_addr_tw;
    logic       gen_valid, gen_finished;
    logic       rd_en;
    logic [7:0] rd_addr0, rd_addr1;
    logic [6:0] rd_addr_tw;
    logic       bf_in_valid, wr_en;
    logic [7:0] wr_addr0, wr_addr1;
    logic       busy, done, overflow;
    logic [15:0] stall_cycles;

    int checks_total  = 0;
    int checks_passed = 0;

`ifdef NTT_SEQ_PERF_EN
    localparam logic [15:0] HAZ_STALL = 16'd4;
    localparam logic [15:0] OVF_STALL = 16'd40;
`else
    localparam logic [15:0] HAZ_STALL = 16'd0;
    localparam logic [15:0] OVF_STALL = 16'd0;
`endif

    ntt_bf_sequencer dut (
        .clk(clk), .rst(rst), .start(start),
        .gen_addr0(gen_addr0), .gen_addr1(gen_addr1), .gen_addr_tw(gen_addr_tw),
        .gen_valid(gen_valid), .gen_finished(gen_finished),
        .rd_en(rd_en), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .rd_addr_tw(rd_addr_tw),
        .bf_in_valid(bf_in_valid), .wr_en(wr_en), .wr_addr0(wr_addr0), .wr_addr1(wr_addr1),
        .busy(busy), .done(done), .overflow(overflow), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic drive_triple(input logic v, input logic [7:0] a0, input logic [7:0] a1,
                                input logic [6:0] tw);
        gen_valid = v; gen_addr0 = a0; gen_addr1 = a1; gen_addr_tw = tw;
    endtask

    task automatic finish_transform(input int budget, output int pulses, output int writes);
        pulses = 0; writes = 0;
        @(negedge clk); gen_finished = 1'b1;
        @(negedge clk); gen_finished = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
            if (wr_en === 1'b1) writes++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks_total++;
        if ({rd_en, bf_in_valid, wr_en, busy, done, overflow} !== 6'b0)
            $display("[TB] FAIL reset_flags: got %b want 000000",
                     {rd_en, bf_in_valid, wr_en, busy, done, overflow});
        else checks_passed++;
        checks_total++;
        if ({rd_addr0, rd_addr1, rd_addr_tw, wr_addr0, wr_addr1} !== 39'd0)
            $display("[TB] FAIL reset_addrs: got %h want 0",
                     {rd_addr0, rd_addr1, rd_addr_tw, wr_addr0, wr_addr1});
        else checks_passed++;
        checks_total++;
        if (stall_cycles !== 16'd0) $display("[TB] FAIL reset_stall: got %0d want 0", stall_cycles);
        else checks_passed++;
        rst = 1'b0;
    endtask

    task automatic test_single();
        int pulses, writes;
        pulse_start();
        drive_triple(1'b1, 8'd0, 8'd128, 7'd1);
        @(negedge clk); gen_valid = 1'b0;
        checks_total++;
        if ({rd_en, rd_addr0, rd_addr1, rd_addr_tw} !== {1'b1, 8'd0, 8'd128, 7'd1})
            $display("[TB] FAIL single_issue: got en=%b %0d/%0d/%0d want en=1 0/128/1",
                     rd_en, rd_addr0, rd_addr1, rd_addr_tw);
        else checks_passed++;
        checks_total++;
        if ({busy, bf_in_valid} !== 2'b10)
            $display("[TB] FAIL single_busy_bf_c: got %b want 10", {busy, bf_in_valid});
        else checks_passed++;
        @(negedge clk);
        checks_total++;
        if ({rd_en, bf_in_valid, wr_en} !== 3'b010)
            $display("[TB] FAIL single_bf_c1: got %b want 010", {rd_en, bf_in_valid, wr_en});
        else checks_passed++;
        repeat (2) @(negedge clk);
        checks_total++;
        if ({bf_in_valid, wr_en} !== 2'b00)
            $display("[TB] FAIL single_c3: got %b want 00", {bf_in_valid, wr_en});
        else checks_passed++;
        @(negedge clk);
        checks_total++;
        if ({wr_en, wr_addr0, wr_addr1} !== {1'b1, 8'd0, 8'd128})
            $display("[TB] FAIL single_wb: got en=%b %0d/%0d want en=1 0/128", wr_en, wr_addr0, wr_addr1);
        else checks_passed++;
        @(negedge clk);
        checks_total++;
        if (wr_en !== 1'b0) $display("[TB] FAIL single_wb_once: got %b want 0", wr_en);
        else checks_passed++;
        finish_transform(12, pulses, writes);
        checks_total++;
        if (pulses !== 1) $display("[TB] FAIL single_done: got %0d pulses want 1", pulses);
        else checks_passed++;
        checks_total++;
        if (busy !== 1'b0) $display("[TB] FAIL single_busy_end: got %b want 0", busy);
        else checks_passed++;
    endtask

    task automatic test_hazard();
        int rd_cyc[$], wr_cyc[$];
        logic [7:0] rd_a0s[$], rd_a1s[$];
        int pulses, writes;
        pulse_start();
        for (int cyc = 0; cyc < 14; cyc++) begin
            @(negedge clk);
            if (rd_en === 1'b1) begin rd_cyc.push_back(cyc); rd_a0s.push_back(rd_addr0); rd_a1s.push_back(rd_addr1); end
            if (wr_en === 1'b1) wr_cyc.push_back(cyc);
            if (cyc == 0)      drive_triple(1'b1, 8'd0, 8'd2, 7'd5);
            else if (cyc == 1) drive_triple(1'b1, 8'd2, 8'd4, 7'd5);
            else               gen_valid = 1'b0;
        end
        checks_total++;
        if (rd_cyc.size() != 2 || wr_cyc.size() != 2)
            $display("[TB] FAIL hazard_counts: got rd=%0d wr=%0d want 2/2", rd_cyc.size(), wr_cyc.size());
        else begin
            checks_passed++;
            checks_total++;
            if (rd_cyc[0] != 1 || wr_cyc[0] != 5)
                $display("[TB] FAIL hazard_first: got rd@%0d wr@%0d want rd@1 wr@5", rd_cyc[0], wr_cyc[0]);
            else checks_passed++;
            checks_total++;
            if (rd_cyc[1] != 6)
                $display("[TB] FAIL hazard_second_rd: got cycle %0d want 6", rd_cyc[1]);
            else checks_passed++;
            checks_total++;
            if ({rd_a0s[1], rd_a1s[1]} !== {8'd2, 8'd4})
                $display("[TB] FAIL hazard_second_addr: got %0d/%0d want 2/4", rd_a0s[1], rd_a1s[1]);
            else checks_passed++;
            checks_total++;
            if (wr_cyc[1] != 10)
                $display("[TB] FAIL hazard_second_wr: got cycle %0d want 10", wr_cyc[1]);
            else checks_passed++;
        end
        checks_total++;
        if (stall_cycles !== HAZ_STALL)
            $display("[TB] FAIL hazard_stall: got %0d want %0d", stall_cycles, HAZ_STALL);
        else checks_passed++;
        finish_transform(12, pulses, writes);
        checks_total++;
        if (pulses !== 1) $display("[TB] FAIL hazard_done: got %0d pulses want 1", pulses);
        else checks_passed++;
    endtask

    // Leaves the sequencer in RUN with the FIFO and pipeline empty for test_start_in_run.
    task automatic test_overflow();
        logic [7:0] wr_a1s[$];
        logic [7:0] exp_a1;
        pulse_start();
        for (int cyc = 0; cyc < 62; cyc++) begin
            @(negedge clk);
            if (wr_en === 1'b1) wr_a1s.push_back(wr_addr1);
            if (cyc == 10) begin
                checks_total++;
                if (overflow !== 1'b0) $display("[TB] FAIL ovf_before: got %b want 0", overflow);
                else checks_passed++;
            end
            if (cyc == 11) begin
                checks_total++;
                if (overflow !== 1'b1) $display("[TB] FAIL ovf_set: got %b want 1", overflow);
                else checks_passed++;
            end
            if (cyc < 12) drive_triple(1'b1, 8'd10, 8'(101 + cyc), 7'(cyc + 1));
            else          gen_valid = 1'b0;
        end
        checks_total++;
        if (wr_a1s.size() != 11)
            $display("[TB] FAIL ovf_write_count: got %0d want 11", wr_a1s.size());
        else begin
            checks_passed++;
            for (int i = 0; i < 11; i++) begin
                exp_a1 = (i < 10) ? 8'(101 + i) : 8'd112;
                checks_total++;
                if (wr_a1s[i] !== exp_a1)
                    $display("[TB] FAIL ovf_write_order[%0d]: got %0d want %0d", i, wr_a1s[i], exp_a1);
                else checks_passed++;
            end
        end
        checks_total++;
        if (stall_cycles !== OVF_STALL)
            $display("[TB] FAIL ovf_stall: got %0d want %0d", stall_cycles, OVF_STALL);
        else checks_passed++;
    endtask

    task automatic test_start_in_run();
        int pulses, writes;
        pulse_start();
        @(negedge clk);
        checks_total++;
        if ({busy, overflow} !== 2'b11)
            $display("[TB] FAIL run_start_flags: got busy,ovf=%b want 11", {busy, overflow});
        else checks_passed++;
        checks_total++;
        if (stall_cycles !== OVF_STALL)
            $display("[TB] FAIL run_start_stall: got %0d want %0d", stall_cycles, OVF_STALL);
        else checks_passed++;
        finish_transform(12, pulses, writes);
        checks_total++;
        if ({pulses == 1, busy, overflow} !== 3'b101)
            $display("[TB] FAIL run_idle_sticky: got pulses=%0d busy=%b ovf=%b want 1/0/1", pulses, busy, overflow);
        else checks_passed++;
        pulse_start();
        checks_total++;
        if ({busy, overflow, stall_cycles} !== {2'b10, 16'd0})
            $display("[TB] FAIL restart_clear: got busy=%b ovf=%b stall=%0d want 1/0/0", busy, overflow, stall_cycles);
        else checks_passed++;
        finish_transform(12, pulses, writes);
        checks_total++;
        if (pulses !== 1) $display("[TB] FAIL restart_done: got %0d pulses want 1", pulses);
        else checks_passed++;
    endtask

    task automatic test_reset_inflight();
        int n_wr = 0, n_rd = 0, n_busy = 0, n_done = 0, pulses, writes;
        pulse_start();
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clk);
            if (cyc < 3) drive_triple(1'b1, 8'(2 * cyc + 1), 8'(2 * cyc + 2), 7'd3);
            else         gen_valid = 1'b0;
        end
        checks_total++;
        if ({rd_en, rd_addr0} !== {1'b1, 8'd5})
            $display("[TB] FAIL rstfly_third_issue: got en=%b a0=%0d want 1/5", rd_en, rd_addr0);
        else checks_passed++;
        rst = 1'b1;
        #1;
        checks_total++;
        if ({rd_en, bf_in_valid, wr_en, busy, done} !== 5'b0)
            $display("[TB] FAIL rstfly_async: got %b want 00000", {rd_en, bf_in_valid, wr_en, busy, done});
        else checks_passed++;
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            n_wr += int'(wr_en === 1'b1); n_rd += int'(rd_en === 1'b1);
            n_busy += int'(busy === 1'b1); n_done += int'(done === 1'b1);
        end
        checks_total++;
        if ({n_wr, n_rd, n_busy, n_done} != 128'd0)
            $display("[TB] FAIL rstfly_quiet: got wr=%0d rd=%0d busy=%0d done=%0d want 0/0/0/0", n_wr, n_rd, n_busy, n_done);
        else checks_passed++;
        pulse_start();
        finish_transform(12, pulses, writes);
        checks_total++;
        if (pulses != 1 || writes != 0)
            $display("[TB] FAIL rstfly_fifo_empty: got done=%0d writes=%0d want 1/0", pulses, writes);
        else checks_passed++;
    endtask

    task automatic test_full_run();
        logic [7:0] ea0[896], ea1[896];
        logic [6:0] etw[896];
        int stamp[256];
        int n = 0, k = 0, gi = 0, ri = 0, wi = 0, dones = 0, extra_done = 0;
        for (int len = 128; len >= 2; len = len / 2) begin
            for (int st = 0; st < 256; st = st + 2 * len) begin
                k++;
                for (int j = st; j < st + len; j++) begin
                    ea0[n] = 8'(j); ea1[n] = 8'(j + len); etw[n] = 7'(k); n++;
                end
            end
        end
        for (int a = 0; a < 256; a++) stamp[a] = 0;
        pulse_start();
        for (int cyc = 0; cyc < 3000 && dones == 0; cyc++) begin
            @(negedge clk);
            if (rd_en === 1'b1) begin
                checks_total++;
                if (ri >= 896) $display("[TB] FAIL full_extra_read: read %0d beyond 896", ri);
                else if ({rd_addr0, rd_addr1, rd_addr_tw} !== {ea0[ri], ea1[ri], etw[ri]})
                    $display("[TB] FAIL full_rd[%0d]: got %0d/%0d/%0d want %0d/%0d/%0d", ri,
                             rd_addr0, rd_addr1, rd_addr_tw, ea0[ri], ea1[ri], etw[ri]);
                else if (stamp[rd_addr0] != ri / 128 || stamp[rd_addr1] != ri / 128)
                    $display("[TB] FAIL full_raw[%0d]: got layers %0d/%0d want %0d", ri,
                             stamp[rd_addr0], stamp[rd_addr1], ri / 128);
                else checks_passed++;
                ri++;
            end
            if (wr_en === 1'b1) begin
                checks_total++;
                if (wi >= 896) $display("[TB] FAIL full_extra_write: write %0d beyond 896", wi);
                else if ({wr_addr0, wr_addr1} !== {ea0[wi], ea1[wi]})
                    $display("[TB] FAIL full_wr[%0d]: got %0d/%0d want %0d/%0d", wi, wr_addr0, wr_addr1, ea0[wi], ea1[wi]);
                else if (stamp[wr_addr0] != wi / 128 || stamp[wr_addr1] != wi / 128)
                    $display("[TB] FAIL full_once[%0d]: got writes %0d/%0d want %0d", wi,
                             stamp[wr_addr0], stamp[wr_addr1], wi / 128);
                else checks_passed++;
                stamp[wr_addr0]++; stamp[wr_addr1]++;
                wi++;
            end
            if (done === 1'b1) dones++;
            if (gi < 896) begin drive_triple(1'b1, ea0[gi], ea1[gi], etw[gi]); gi++; end
            else begin gen_valid = 1'b0; gen_finished = (gi == 896); gi++; end
        end
        gen_finished = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            extra_done += int'(done === 1'b1);
        end
        checks_total++;
        if (ri != 896 || wi != 896)
            $display("[TB] FAIL full_counts: got rd=%0d wr=%0d want 896/896", ri, wi);
        else checks_passed++;
        checks_total++;
        if (dones + extra_done != 1)
            $display("[TB] FAIL full_done: got %0d pulses want 1", dones + extra_done);
        else checks_passed++;
        checks_total++;
        if ({overflow, busy} !== 2'b00)
            $display("[TB] FAIL full_end_flags: got ovf,busy=%b want 00", {overflow, busy});
        else checks_passed++;
    endtask

    initial begin
        start = 1'b0; gen_valid = 1'b0; gen_finished = 1'b0;
        gen_addr0 = '0; gen_addr1 = '0; gen_addr_tw = '0;
        test_reset();
        test_single();
        test_hazard();
        test_overflow();
        test_start_in_run();
        test_reset_inflight();
        test_full_run();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
